// File: rtl/cpu_pkg.sv
// Shared register-file write-path types: the ME/WB pipeline entry and well-known GPR indices.
// Pure declarations, no latency or flow control of its own.
package cpu_pkg;

  localparam int CPU_DW = 32;
  localparam int CPU_AW = 5;

  localparam logic [CPU_AW-1:0] REG_ZERO = 5'd0;
  localparam logic [CPU_AW-1:0] REG_RA   = 5'd31;

  typedef struct packed {
    logic              we;
    logic              is_load;
    logic [CPU_AW-1:0] waddr;
    logic [CPU_DW-1:0] data;
  } wb_entry_t;

  localparam int ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_stage_reg.sv
// One pipeline register for a pending GPR write; 1-cycle latency.
// On hold it either keeps its entry or, with BUBBLE_ON_HOLD, loads an empty entry.
module wb_stage_reg
  import cpu_pkg::*;
#(
  parameter bit BUBBLE_ON_HOLD = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               hold,
  input  logic [ENTRY_W-1:0] d,
  output logic [ENTRY_W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (!hold) begin
      q <= d;
    end else if (BUBBLE_ON_HOLD) begin
      q <= '0;
    end
  end

endmodule

// File: rtl/writeback_pipe.sv
// Carries GPR writes EX->ME->WB, drives the forwarding triplets, RF write port and load-use stall.
// EX to RF commit is 2 cycles plus one per hold_me cycle; hold_me freezes ME and bubbles WB.
module writeback_pipe
  import cpu_pkg::*;
#(
  parameter int DW = CPU_DW,
  parameter int AW = CPU_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ex_valid,
  input  logic          ex_we,
  input  logic [AW-1:0] ex_waddr,
  input  logic [DW-1:0] ex_result,
  input  logic          ex_is_load,
  input  logic          flush_ex,
  input  logic          hold_me,
  input  logic [DW-1:0] dmem_rdata,
  input  logic [AW-1:0] id_r1_addr,
  input  logic [AW-1:0] id_r2_addr,
  input  logic          id_r1_use,
  input  logic          id_r2_use,
  output logic          we_ex,
  output logic [AW-1:0] wa_ex,
  output logic [DW-1:0] wd_ex,
  output logic          we_me,
  output logic [AW-1:0] wa_me,
  output logic [DW-1:0] wd_me,
  output logic          we_wb,
  output logic [AW-1:0] wa_wb,
  output logic [DW-1:0] wd_wb,
  output logic          we,
  output logic [AW-1:0] w_addr,
  output logic [DW-1:0] w_data,
  output logic          stall_req,
  output logic [31:0]   retired_cnt
);

  logic      ex_wv;
  wb_entry_t me_d, me_q;
  wb_entry_t wb_d, wb_q;

  assign ex_wv = ex_valid & ex_we & ~flush_ex & (ex_waddr != REG_ZERO);

  assign we_ex = ex_wv & ~ex_is_load;
  assign wa_ex = ex_waddr;
  assign wd_ex = ex_result;

  assign me_d = '{we: ex_wv, is_load: ex_is_load, waddr: ex_waddr, data: ex_result};

  wb_stage_reg #(.BUBBLE_ON_HOLD(1'b0)) u_me_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (hold_me),
    .d    (me_d),
    .q    (me_q)
  );

  // Load data exists only during ME, so it is muxed in here and sampled into WB.
  assign we_me = me_q.we;
  assign wa_me = me_q.waddr;
  assign wd_me = me_q.is_load ? dmem_rdata : me_q.data;

  assign wb_d = '{we: we_me, is_load: 1'b0, waddr: wa_me, data: wd_me};

  // A held ME entry must not commit once per held cycle, hence the bubble.
  wb_stage_reg #(.BUBBLE_ON_HOLD(1'b1)) u_wb_reg (
    .clk  (clk),
    .rst  (rst),
    .hold (hold_me),
    .d    (wb_d),
    .q    (wb_q)
  );

  assign we_wb  = wb_q.we;
  assign wa_wb  = wb_q.waddr;
  assign wd_wb  = wb_q.data;
  assign we     = we_wb;
  assign w_addr = wa_wb;
  assign w_data = wd_wb;

  assign stall_req = ex_wv & ex_is_load &
                     ((id_r1_use & (id_r1_addr == ex_waddr)) |
                      (id_r2_use & (id_r2_addr == ex_waddr)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      retired_cnt <= '0;
    end else if (we_wb) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_writeback_pipe.sv
// Directed bench for writeback_pipe with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are compared before the next edge.
module tb_writeback_pipe;

  logic        clk;
  logic        rst;
  logic        ex_valid, ex_we, ex_is_load, flush_ex, hold_me;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_result, dmem_rdata;
  logic [4:0]  id_r1_addr, id_r2_addr;
  logic        id_r1_use, id_r2_use;
  logic        we_ex, we_me, we_wb, we, stall_req;
  logic [4:0]  wa_ex, wa_me, wa_wb, w_addr;
  logic [31:0] wd_ex, wd_me, wd_wb, w_data, retired_cnt;

  int n_checks = 0;
  int n_errors = 0;

  writeback_pipe dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_we(ex_we), .ex_waddr(ex_waddr), .ex_result(ex_result),
    .ex_is_load(ex_is_load), .flush_ex(flush_ex), .hold_me(hold_me), .dmem_rdata(dmem_rdata),
    .id_r1_addr(id_r1_addr), .id_r2_addr(id_r2_addr), .id_r1_use(id_r1_use), .id_r2_use(id_r2_use),
    .we_ex(we_ex), .wa_ex(wa_ex), .wd_ex(wd_ex),
    .we_me(we_me), .wa_me(wa_me), .wd_me(wd_me),
    .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb),
    .we(we), .w_addr(w_addr), .w_data(w_data),
    .stall_req(stall_req), .retired_cnt(retired_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic v, input logic w, input logic [4:0] a,
                          input logic [31:0] r, input logic ld, input logic fl);
    ex_valid   = v;
    ex_we      = w;
    ex_waddr   = a;
    ex_result  = r;
    ex_is_load = ld;
    flush_ex   = fl;
  endtask

  task automatic idle();
    drive_ex(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    idle();
    hold_me = 1'b0; dmem_rdata = 32'h0;
    id_r1_addr = 5'd0; id_r2_addr = 5'd0; id_r1_use = 1'b0; id_r2_use = 1'b0;

    // Reset state
    tick();
    chk("rst_we", {31'd0, we}, 32'd0);
    chk("rst_we_me", {31'd0, we_me}, 32'd0);
    chk("rst_w_data", w_data, 32'd0);
    chk("rst_cnt", retired_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Back-to-back ALU writes
    tick();
    drive_ex(1'b1, 1'b1, 5'd3, 32'h11, 1'b0, 1'b0);
    #1;
    chk("b2b_we_ex", {31'd0, we_ex}, 32'd1);
    chk("b2b_wd_ex", wd_ex, 32'h11);
    tick();
    drive_ex(1'b1, 1'b1, 5'd4, 32'h22, 1'b0, 1'b0);
    #1;
    chk("b2b_we_me", {31'd0, we_me}, 32'd1);
    chk("b2b_wa_me", {27'd0, wa_me}, 32'd3);
    chk("b2b_wd_me", wd_me, 32'h11);
    tick();
    idle();
    #1;
    chk("b2b_we0", {31'd0, we}, 32'd1);
    chk("b2b_wa0", {27'd0, w_addr}, 32'd3);
    chk("b2b_wd0", w_data, 32'h11);
    chk("b2b_wa_me1", {27'd0, wa_me}, 32'd4);
    tick();
    chk("b2b_wa1", {27'd0, w_addr}, 32'd4);
    chk("b2b_wd1", w_data, 32'h22);
    chk("b2b_cnt1", retired_cnt, 32'd1);
    tick();
    chk("b2b_we_idle", {31'd0, we}, 32'd0);
    chk("b2b_cnt2", retired_cnt, 32'd2);

    // Load-use hazard
    drive_ex(1'b1, 1'b1, 5'd5, 32'h1234, 1'b1, 1'b0);
    id_r1_addr = 5'd5; id_r1_use = 1'b1;
    #1;
    chk("lu_stall", {31'd0, stall_req}, 32'd1);
    chk("lu_we_ex", {31'd0, we_ex}, 32'd0);
    tick();
    idle();
    dmem_rdata = 32'hDEAD;
    #1;
    chk("lu_we_me", {31'd0, we_me}, 32'd1);
    chk("lu_wa_me", {27'd0, wa_me}, 32'd5);
    chk("lu_wd_me", wd_me, 32'hDEAD);
    chk("lu_stall_off", {31'd0, stall_req}, 32'd0);
    tick();
    dmem_rdata = 32'hBEEF;
    #1;
    chk("lu_we", {31'd0, we}, 32'd1);
    chk("lu_w_addr", {27'd0, w_addr}, 32'd5);
    chk("lu_w_data", w_data, 32'hDEAD);
    tick();
    chk("lu_cnt", retired_cnt, 32'd3);

    // Stall via operand 2 and its qualifiers
    id_r1_use = 1'b0;
    id_r2_addr = 5'd6; id_r2_use = 1'b1;
    drive_ex(1'b1, 1'b1, 5'd6, 32'h0, 1'b1, 1'b0);
    #1;
    chk("lu2_stall", {31'd0, stall_req}, 32'd1);
    flush_ex = 1'b1;
    #1;
    chk("lu2_flush", {31'd0, stall_req}, 32'd0);
    flush_ex = 1'b0; id_r2_use = 1'b0;
    #1;
    chk("lu2_nouse", {31'd0, stall_req}, 32'd0);
    drive_ex(1'b1, 1'b1, 5'd0, 32'h0, 1'b1, 1'b0);
    id_r2_addr = 5'd0; id_r2_use = 1'b1;
    #1;
    chk("lu2_r0", {31'd0, stall_req}, 32'd0);
    id_r2_use = 1'b0;
    idle();

    // Zero destination and flush
    tick();
    drive_ex(1'b1, 1'b1, 5'd0, 32'h55, 1'b0, 1'b0);
    #1;
    chk("z_we_ex", {31'd0, we_ex}, 32'd0);
    tick();
    drive_ex(1'b1, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
    #1;
    chk("z_we_me", {31'd0, we_me}, 32'd0);
    chk("fl_we_ex", {31'd0, we_ex}, 32'd0);
    tick();
    idle();
    #1;
    chk("z_we", {31'd0, we}, 32'd0);
    chk("fl_we_me", {31'd0, we_me}, 32'd0);
    tick();
    chk("fl_we", {31'd0, we}, 32'd0);
    chk("zf_cnt", retired_cnt, 32'd3);

    // hold_me for 3 cycles
    drive_ex(1'b1, 1'b1, 5'd9, 32'h99, 1'b0, 1'b0);
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      hold_me = (c <= 3);
      #1;
      chk($sformatf("h_we_me_c%0d", c), {31'd0, we_me}, 32'd1);
      chk($sformatf("h_wd_me_c%0d", c), wd_me, 32'h99);
      chk($sformatf("h_we_c%0d", c), {31'd0, we}, 32'd0);
      tick();
    end
    hold_me = 1'b0;
    #1;
    chk("h_commit_we", {31'd0, we}, 32'd1);
    chk("h_commit_wa", {27'd0, w_addr}, 32'd9);
    chk("h_commit_wd", w_data, 32'h99);
    chk("h_me_empty", {31'd0, we_me}, 32'd0);
    tick();
    chk("h_once", {31'd0, we}, 32'd0);
    chk("h_cnt", retired_cnt, 32'd4);

    // Async reset mid-stream
    drive_ex(1'b1, 1'b1, 5'd11, 32'hAA, 1'b0, 1'b0);
    tick();
    drive_ex(1'b1, 1'b1, 5'd12, 32'hBB, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    chk("ar_pre_we", {31'd0, we}, 32'd1);
    chk("ar_pre_we_me", {31'd0, we_me}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_we", {31'd0, we}, 32'd0);
    chk("ar_we_wb", {31'd0, we_wb}, 32'd0);
    chk("ar_we_me", {31'd0, we_me}, 32'd0);
    chk("ar_w_data", w_data, 32'd0);
    chk("ar_cnt", retired_cnt, 32'd0);
    tick();
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("ar_post_we", {31'd0, we}, 32'd0);
    tick();
    chk("ar_post_we2", {31'd0, we}, 32'd0);
    chk("ar_post_cnt", retired_cnt, 32'd0);

    // Counter wrap
    force dut.retired_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retired_cnt;
    #1;
    chk("wrap_pre", retired_cnt, 32'hFFFF_FFFF);
    tick();
    drive_ex(1'b1, 1'b1, 5'd1, 32'h1, 1'b0, 1'b0);
    tick();
    idle();
    tick();
    chk("wrap_we", {31'd0, we}, 32'd1);
    chk("wrap_hold", retired_cnt, 32'hFFFF_FFFF);
    tick();
    chk("wrap_cnt", retired_cnt, 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_pipe.md
Name: writeback_pipe

Overview:
- Write-side producer for the CPU register file. Carries each instruction's destination write from EX through the ME and WB pipeline registers.
- Drives the three forwarding triplets (EX, ME, WB) and the architectural write port (we / w_addr / w_data) that the register file consumes.
- Detects load-use hazards, since load data does not exist in EX, and raises a stall request to decode.
- Keeps a retired-write counter for debug.

Parameters:
- DW, 32, data width of register values.
- AW, 5, register address width (32 GPRs, index 0 hard-wired zero).

Ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  asynchronous active-low reset
- ex_valid  in  1  EX holds a real instruction
- ex_we  in  1  EX instruction writes a GPR
- ex_waddr  in  AW  EX destination register
- ex_result  in  DW  EX ALU/link result
- ex_is_load  in  1  EX instruction is a load (result comes from dmem in ME)
- flush_ex  in  1  kill EX instruction (branch/jump redirect)
- hold_me  in  1  ME must not advance (memory busy)
- dmem_rdata  in  DW  load data, valid combinationally during ME
- id_r1_addr, id_r2_addr  in  AW  decode read addresses
- id_r1_use, id_r2_use  in  1  decode actually reads that operand
- we_ex, wa_ex, wd_ex  out  1/AW/DW  EX forwarding triplet
- we_me, wa_me, wd_me  out  1/AW/DW  ME forwarding triplet
- we_wb, wa_wb, wd_wb  out  1/AW/DW  WB forwarding triplet
- we, w_addr, w_data  out  1/AW/DW  register-file write port, equal to the WB triplet
- stall_req  out  1  load-use hazard; decode must hold and inject a bubble into EX
- retired_cnt  out  32  count of committed GPR writes

Behaviour:
- Reset (rst=0, async): ME and WB valid/we = 0; addresses and data = 0; retired_cnt = 0. All registered outputs read 0 immediately. Reset mid-stream drops in-flight writes with no partial commit.
- Qualified EX write: ex_wv = ex_valid & ex_we & ~flush_ex & (ex_waddr != 0).
- EX triplet (combinational): we_ex = ex_wv & ~ex_is_load; wa_ex = ex_waddr; wd_ex = ex_result.
- ME capture, per rising edge:
  - hold_me=1: ME holds.
  - otherwise ME <= {ex_wv, ex_is_load, ex_waddr, ex_result}. A flushed or zero-destination instruction therefore enters ME as a bubble (we=0).
- ME triplet: we_me = ME.we; wa_me = ME.waddr; wd_me = ME.is_load ? dmem_rdata : ME.result.
- WB capture, per rising edge:
  - hold_me=1: WB <= bubble (we=0). This prevents a held ME instruction from committing twice.
  - otherwise WB <= {we_me, wa_me, wd_me}, i.e. load data is sampled at the end of ME.
- WB triplet and write port: we = we_wb = WB.we; w_addr = wa_wb; w_data = wd_wb. Latency from EX to RF commit is exactly 2 cycles with no holds, plus 1 cycle per hold_me cycle.
- stall_req (combinational): ex_valid & ex_is_load & ex_we & ~flush_ex & (ex_waddr != 0) & ((id_r1_use & id_r1_addr == ex_waddr) | (id_r2_use & id_r2_addr == ex_waddr)).
  - Deasserts on the next cycle once decode has injected its bubble, because the load has moved to ME and is now forwarded via we_me.
- hold_me and EX: while hold_me=1, the EX instruction is not captured. Upstream must hold EX stable; this block keeps no EX state.
- Priority: flush_ex and hold_me together means ME holds, and the flushed EX instruction is lost (upstream re-fetches).
- retired_cnt increments by 1 each cycle WB.we=1. It wraps modulo 2^32 (0xFFFFFFFF -> 0).
- Address 0: never produces we=1 on any triplet or on the write port.
- Multiple matching stages: the consumer gives priority EX > ME > WB. This block guarantees each triplet reflects its own stage only.

Decomposition:
- Shared package cpu_pkg holds:
  - REG_ZERO = 5'd0, REG_RA = 5'd31.
  - Struct wb_entry_t {we, is_load, waddr[AW], data[DW]} used for the ME and WB registers.
- One natural sub-module: wb_stage_reg, a single valid/hold/bubble pipeline register instantiated twice (ME, WB).
- Hazard logic and the retired counter stay in the top.

Test Plan:
- Back-to-back ALU writes: EX writes r3=0x11, then r4=0x22 the next cycle, no hold -> wd_ex=0x11 in cycle 0; we_me/wa_me=3/wd_me=0x11 in cycle 1; we=1, w_addr=3, w_data=0x11 in cycle 2; r4 follows one cycle later; retired_cnt=2.
- Load-use: EX load r5, id_r1_addr=5, id_r1_use=1 -> stall_req=1 and we_ex=0. Next cycle dmem_rdata=0xDEAD -> we_me=1, wd_me=0xDEAD, stall_req=0. Cycle after -> w_data=0xDEAD.
- Zero and flush: EX writes r0=0x55 -> we_ex/we_me/we all 0. EX writes r7 with flush_ex=1 -> no triplet ever asserts for r7; retired_cnt unchanged.
- hold_me for 3 cycles with ME holding r9=0x99 -> we_me stays 1 for 4 cycles, WB is a bubble for 3 cycles, then exactly one commit r9=0x99 (retired_cnt +1).
- Async reset asserted mid-cycle while ME and WB hold valid writes -> we, we_me, we_wb, retired_cnt drop to 0 immediately without waiting for clk; no write after release.
- Counter wrap: force retired_cnt to 0xFFFFFFFF, commit one write -> retired_cnt=0x00000000.
